// File: rtl/reg_scoreboard_ctrl_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
//   REGNOBITS          : width of a GPR index
//   *_DEF              : default values for the top-level parameters
//   sb_entry_t         : one in-flight record {wr_reg, rd, wr_csr}; packed with
//                        wr_reg in the MSB, rd in the middle, wr_csr in bit 0
//   sb_entry_matches() : compares a stored record with the retiring WB fields
package reg_scoreboard_ctrl_pkg;

  localparam int REGNOBITS          = 5;
  localparam int INFLIGHT_DEPTH_DEF = 4;
  localparam int CNTW_DEF           = 3;
  localparam int NREGS_DEF          = 32;

  typedef struct packed {
    logic                 wr_reg;
    logic [REGNOBITS-1:0] rd;
    logic                 wr_csr;
  } sb_entry_t;

  function automatic logic sb_entry_matches(input sb_entry_t            e,
                                            input logic                 wr_reg,
                                            input logic [REGNOBITS-1:0] rd,
                                            input logic                 wr_csr);
    return (e.wr_reg == wr_reg) && (e.rd == rd) && (e.wr_csr == wr_csr);
  endfunction

endpackage

// File: rtl/reg_scoreboard_ctrl_if.sv
// Bundle between FE/DE, the AGEX/WB datapath and the scoreboard.
//   de_*          : decoded instruction presented by DE
//   wb_*          : instruction retiring this cycle
//   flush/flush_cnt : AGEX branch clear, number of youngest entries to squash
//   stall/issue   : combinational hold/accept back to DE
//   inflight_cnt  : live in-flight entries
//   err           : sticky protocol error
// Handshake: the DE instruction is accepted in a cycle exactly when
// de_valid=1 and issue=1; while stall=1 DE must hold the same instruction and
// FE must hold, and a bubble enters the DE latch. flush overrides issue.
// Modports: master = pipeline side (drives de/wb/flush), slave = scoreboard.
interface reg_scoreboard_ctrl_if
  import reg_scoreboard_ctrl_pkg::*;
#(
  parameter int CW = 3
);

  logic                 de_valid;
  logic                 de_use_rs1;
  logic [REGNOBITS-1:0] de_rs1;
  logic                 de_use_rs2;
  logic [REGNOBITS-1:0] de_rs2;
  logic                 de_rd_csr;
  logic                 de_wr_reg;
  logic [REGNOBITS-1:0] de_rd;
  logic                 de_wr_csr;
  logic                 wb_valid;
  logic                 wb_wr_reg;
  logic [REGNOBITS-1:0] wb_rd;
  logic                 wb_wr_csr;
  logic                 flush;
  logic [CW-1:0]        flush_cnt;
  logic                 stall;
  logic                 issue;
  logic [CW-1:0]        inflight_cnt;
  logic                 err;

  modport master (
    output de_valid, de_use_rs1, de_rs1, de_use_rs2, de_rs2, de_rd_csr,
           de_wr_reg, de_rd, de_wr_csr, wb_valid, wb_wr_reg, wb_rd, wb_wr_csr,
           flush, flush_cnt,
    input  stall, issue, inflight_cnt, err
  );

  modport slave (
    input  de_valid, de_use_rs1, de_rs1, de_use_rs2, de_rs2, de_rd_csr,
           de_wr_reg, de_rd, de_wr_csr, wb_valid, wb_wr_reg, wb_rd, wb_wr_csr,
           flush, flush_cnt,
    output stall, issue, inflight_cnt, err
  );

endinterface

// File: rtl/reg_scoreboard_ctrl_sb_inflight_fifo.sv
// sb_inflight_fifo: in-order circular buffer of in-flight scoreboard records.
//   clk, reset   : clock, asynchronous active-low reset
//   push/push_entry : append at the tail
//   pop          : drop the head
//   squash_n     : drop this many youngest entries (tail moves back)
//   clear        : drop every live entry
//   head         : oldest live record
//   slots        : raw storage, indexed by slot
//   squash_mask  : slots leaving this cycle via squash_n or clear
//   count        : live entries
// The owner never pushes and squashes in the same cycle, and keeps
// pop + squash_n <= count unless it asserts clear.
module sb_inflight_fifo
  import reg_scoreboard_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [CW-1:0]         squash_n,
  output sb_entry_t             head,
  output sb_entry_t [DEPTH-1:0] slots,
  output logic [DEPTH-1:0]      squash_mask,
  output logic [CW-1:0]         count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         head_ptr;
  logic [PW-1:0]         tail_ptr;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         slot_off [DEPTH];

  // With DEPTH a power of two the pointer wraps for free; a full buffer has
  // tail_ptr == head_ptr.
  assign tail_ptr = head_ptr + PW'(cnt);
  assign head     = mem[head_ptr];
  assign slots    = mem;
  assign count    = cnt;

  // slot_off is a slot's age from the head (0 = oldest). The squashed ones are
  // the youngest squash_n live slots.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      slot_off[s]    = PW'(s) - head_ptr;
      squash_mask[s] = (CW'(slot_off[s]) < cnt) &&
                       (clear || (CW'(slot_off[s]) >= (cnt - squash_n)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem      <= '0;
      head_ptr <= '0;
      cnt      <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      if (push) mem[tail_ptr] <= push_entry;
      if (pop)  head_ptr <= head_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop) - squash_n;
    end
  end

endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: register-hazard scheduler between DE and AGEX/MEM/WB.
// Tracks in-flight GPR and CSR writes, decides whether the DE instruction may
// issue, retires at WB and squashes youngest entries on a branch clear.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   sb    : reg_scoreboard_ctrl_if.slave (DE, WB, flush in; stall, issue,
//           inflight_cnt, err out)
module reg_scoreboard_ctrl
  import reg_scoreboard_ctrl_pkg::*;
#(
  parameter int INFLIGHT_DEPTH = INFLIGHT_DEPTH_DEF,
  parameter int CNTW           = CNTW_DEF,
  parameter int NREGS          = NREGS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_scoreboard_ctrl_if.slave sb
);

  localparam int CW      = $clog2(INFLIGHT_DEPTH + 1);
  localparam int CW1     = CW + 1;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic [CNTW-1:0]                busy_cnt [NREGS];
  logic [CNTW-1:0]                busy_nxt [NREGS];
  logic [CNTW-1:0]                csr_cnt;
  logic [CNTW-1:0]                csr_nxt;
  logic                           csr_busy;
  logic                           err_q;
  logic                           cnt_err;

  sb_entry_t                      de_entry;
  sb_entry_t                      head;
  sb_entry_t [INFLIGHT_DEPTH-1:0] slots;
  logic [INFLIGHT_DEPTH-1:0]      squash_mask;
  logic [CW-1:0]                  count;
  logic [CW-1:0]                  squash_n;

  logic wb_reg_now, rs1_free, rs2_free, csr_free, fifo_full, hazard;
  logic overrun, empty_pop, do_pop, mismatch, stall_c, issue_c;

  assign de_entry   = {sb.de_wr_reg, sb.de_rd, sb.de_wr_csr};
  assign wb_reg_now = sb.wb_valid & sb.wb_wr_reg;
  assign csr_busy   = |csr_cnt;

  // A register whose last outstanding writer retires this cycle is readable:
  // the RF is written on the falling edge.
  always_comb begin
    rs1_free = (sb.de_rs1 == '0) || (busy_cnt[sb.de_rs1] == '0) ||
               ((busy_cnt[sb.de_rs1] == CNTW'(1)) && wb_reg_now && (sb.wb_rd == sb.de_rs1));
    rs2_free = (sb.de_rs2 == '0) || (busy_cnt[sb.de_rs2] == '0) ||
               ((busy_cnt[sb.de_rs2] == CNTW'(1)) && wb_reg_now && (sb.wb_rd == sb.de_rs2));
    csr_free = !csr_busy || ((csr_cnt == CNTW'(1)) && sb.wb_valid && sb.wb_wr_csr);
  end

  // Fullness is judged after this cycle's retire, so a full buffer with a
  // retiring instruction still accepts.
  assign fifo_full = (count == CW'(INFLIGHT_DEPTH)) && !sb.wb_valid;
  assign hazard    = fifo_full | (sb.de_use_rs1 & ~rs1_free) |
                     (sb.de_use_rs2 & ~rs2_free) | (sb.de_rd_csr & ~csr_free);
  assign stall_c   = reset & sb.de_valid & ~sb.flush & hazard;
  assign issue_c   = reset & sb.de_valid & ~sb.flush & ~stall_c;

  // Retire/squash bookkeeping. Asking to remove more entries than are live
  // is a protocol error; the buffer is emptied so the counters stay coherent.
  assign overrun   = sb.flush &&
                     (({1'b0, sb.flush_cnt} + CW1'(sb.wb_valid)) > {1'b0, count});
  assign empty_pop = sb.wb_valid && !sb.flush && (count == '0);
  assign do_pop    = sb.wb_valid && (count != '0) && !overrun;
  assign squash_n  = (sb.flush && !overrun) ? sb.flush_cnt : '0;
  assign mismatch  = do_pop &&
                     !sb_entry_matches(head, sb.wb_wr_reg, sb.wb_rd, sb.wb_wr_csr);

  sb_inflight_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (issue_c),
    .push_entry  (de_entry),
    .pop         (do_pop),
    .clear       (overrun),
    .squash_n    (squash_n),
    .head        (head),
    .slots       (slots),
    .squash_mask (squash_mask),
    .count       (count)
  );

  // One signed sum per counter so issue, retire and any number of squashes
  // hitting the same register in one cycle combine exactly.
  always_comb begin
    int nxt;
    int cnxt;
    cnt_err = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      nxt = int'(busy_cnt[r]);
      if (issue_c && sb.de_wr_reg && (sb.de_rd == REGNOBITS'(r))) nxt = nxt + 1;
      if (do_pop && head.wr_reg && (head.rd == REGNOBITS'(r)))     nxt = nxt - 1;
      for (int s = 0; s < INFLIGHT_DEPTH; s++) begin
        if (squash_mask[s] && slots[s].wr_reg && (slots[s].rd == REGNOBITS'(r))) nxt = nxt - 1;
      end
      busy_nxt[r] = '0;
      if (r != 0) begin
        if (nxt < 0) begin
          cnt_err = 1'b1;
        end else if (nxt > CNT_MAX) begin
          busy_nxt[r] = CNTW'(CNT_MAX);
          cnt_err     = 1'b1;
        end else begin
          busy_nxt[r] = CNTW'(nxt);
        end
      end
    end

    cnxt = int'(csr_cnt);
    if (issue_c && sb.de_wr_csr)  cnxt = cnxt + 1;
    if (do_pop && head.wr_csr)    cnxt = cnxt - 1;
    for (int s = 0; s < INFLIGHT_DEPTH; s++) begin
      if (squash_mask[s] && slots[s].wr_csr) cnxt = cnxt - 1;
    end
    csr_nxt = '0;
    if (cnxt < 0) begin
      cnt_err = 1'b1;
    end else if (cnxt > CNT_MAX) begin
      csr_nxt = CNTW'(CNT_MAX);
      cnt_err = 1'b1;
    end else begin
      csr_nxt = CNTW'(cnxt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) busy_cnt[r] <= '0;
      csr_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) busy_cnt[r] <= busy_nxt[r];
      csr_cnt <= csr_nxt;
      err_q   <= err_q | mismatch | empty_pop | overrun | cnt_err;
    end
  end

  assign sb.stall        = stall_c;
  assign sb.issue        = issue_c;
  assign sb.inflight_cnt = count;
  assign sb.err          = err_q;

endmodule
